nested_ifs_cfg_loader: RTL
==========================

# nested_ifs_cfg_loader

Configuration writer for the `nested_ifs` stateful atom: accepts a stream of 32-bit config words over a valid/ready handshake, assembles them in a shadow register, and atomically commits the full hole set (constants, selectors, relational and arithmetic opcodes) to registered outputs. It sits between the pipeline control plane and the atom's `i__cons_*`, `i__sel_*`, `i__rel_op*` and `i__arith_op*` ports, so the atom never sees a partially updated configuration.

## Interface
- No parameters. Word width (32) and word count are fixed by package constants.
- `clk`  input  1  clock
- `rst`  input  1  synchronous, active-high reset
- `i__cfg_valid`  input  1  config word valid
- `i__cfg_data`  input  32  config word
- `o__cfg_ready`  output  1  loader accepts a word this cycle
- `i__commit_en`  input  1  atom may take a new configuration
- `o__commit`  output  1  one-cycle pulse; new configuration visible this cycle
- `o__busy`  output  1  a load is in progress or waiting to commit
- `o__cfg_err`  output  1  one-cycle checksum-failure pulse (tied 0 without the macro)
- `o__cons_1` … `o__cons_11`  output  32 each  constants
- `o__sel_1..7`, `o__sel_10`, `o__sel_13..16`, `o__sel_19`  output  1 each  2-way selectors
- `o__sel_8`, `o__sel_9`, `o__sel_11`, `o__sel_12`, `o__sel_17`, `o__sel_18`, `o__sel_20`, `o__sel_21`  output  2 each  3-way selectors
- `o__rel_op1..3`  output  2 each;  `o__arith_op1..4`  output  1 each

## Operation
- Word order:
  - Words 0–10 carry `cons_1`–`cons_11`.
  - Word 11 carries `ctl[31:0]`.
  - Word 12 bits [6:0] carry `ctl[38:32]`. Bits [31:7] of word 12 are ignored.
- `ctl` layout, LSB first:
  - sel_1 [0], sel_2 [1], sel_3 [2], sel_4 [3], sel_5 [4], sel_6 [5], sel_7 [6]
  - sel_8 [8:7], sel_9 [10:9], sel_10 [11], sel_11 [13:12], sel_12 [15:14]
  - sel_13 [16], sel_14 [17], sel_15 [18], sel_16 [19], sel_17 [21:20], sel_18 [23:22]
  - sel_19 [24], sel_20 [26:25], sel_21 [28:27]
  - rel_op1 [30:29], rel_op2 [32:31], rel_op3 [34:33]
  - arith_op1 [35], arith_op2 [36], arith_op3 [37], arith_op4 [38]
- A word transfers on `i__cfg_valid && o__cfg_ready`. The word counter is 4 bits and resets to 0 on commit, error or reset.
- FSM states:
  - IDLE: counter 0, ready=1, busy=0. A transfer goes to LOAD, or to WAIT if CFG_WORDS=1 (never the case).
  - LOAD: ready=1, busy=1. The last word (index CFG_WORDS−1) goes to WAIT.
  - WAIT: ready=0, busy=1.
    - If `i__commit_en`=1 (and the checksum is good when the macro is on): shadow is copied to the active outputs, then the FSM goes to IDLE.
    - Otherwise the FSM stays in WAIT indefinitely.
- Active outputs change only on a commit edge. `o__commit` is registered and is high exactly in the first cycle the new values are visible.
- `i__cfg_valid` while ready=0: the word is not taken, and the sender holds it.
- Reset at any point:
  - State goes to IDLE, the counter clears and the shadow is discarded.
  - All active outputs, `o__commit` and `o__cfg_err` become 0.
  - `o__cfg_ready` and `o__busy` are 0 while `rst` is high.

## Timing
- Last word accepted at edge k. State is WAIT in cycle k+1.
- With `i__commit_en` high in cycle k+1: new outputs appear and `o__commit`=1 in cycle k+2, and ready=1 again in cycle k+2.
- Minimum reload period is CFG_WORDS+1 cycles.
- No combinational path from any input to any output except `o__cfg_ready` and `o__busy`, which are decoded from state and `rst`.

## Configuration
- `NESTED_IFS_CFG_CHECK_EN` defined:
  - CFG_WORDS=14. Word 13 is the XOR of words 0–12.
  - In WAIT, a checksum mismatch gives no commit, `o__cfg_err`=1 for one cycle (cycle k+2), return to IDLE, and the active outputs are retained.
  - The checksum is evaluated regardless of `i__commit_en`.
- Undefined: CFG_WORDS=13, no checksum logic, `o__cfg_err` tied 0.

## Structure
- Shared package `nested_ifs_pkg` holds:
  - typedefs `int32_t`, `bool`, `int2_t`;
  - `CFG_WORDS`;
  - `ctl` bit-offset localparams;
  - function `cfg_unpack` mapping the shadow vector to fields.
- One natural sub-module: `nested_ifs_cfg_fsm` (state, counter, ready/busy/commit/err). Field registers stay in the top level.

## Test plan
- Reset, then words 0–10 = 0x11·(k+1), word 11 = 0xFFFF_FFFF, word 12 = 0x7F, commit_en=1 → `o__commit` at k+2, `o__cons_3`=0x33, 1-bit sels=1, 2-bit sels=3, rel_ops=3, arith_ops=1.
- Same load with commit_en=0 for 10 cycles → ready=0, busy=1, outputs unchanged. Raise commit_en → commit pulse next cycle.
- Random valid bubbles and back-to-back loads → identical committed values, no words lost or duplicated.
- Reset after 5 words → all outputs 0. The next full load commits, with word 0 landing in `o__cons_1`.
- Word 12 = 0xFFFF_FF80 → ctl[38:32]=0, upper bits ignored.
- Macro on: wrong checksum → `o__cfg_err` pulse, no `o__commit`, previous config held. Correct checksum → commit.

Source files
------------

// File: rtl/nested_ifs_pkg.sv
// Shared types, word layout and field unpacking for the nested_ifs configuration loader.
// NESTED_IFS_CFG_CHECK_EN adds a trailing XOR checksum word to every load.
package nested_ifs_pkg;

  typedef logic [31:0] int32_t;
  typedef logic        bool;
  typedef logic [1:0]  int2_t;

`ifdef NESTED_IFS_CFG_CHECK_EN
  localparam int CFG_WORDS = 14;
`else
  localparam int CFG_WORDS = 13;
`endif
  localparam int CONS_N = 11;
  localparam int CTL_W  = 39;

  // Bit offsets of each field inside the 39-bit ctl vector
  localparam int SEL_OFS [1:21] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 11, 12, 14, 16, 17, 18, 19,
                                    20, 22, 24, 25, 27};
  localparam logic [21:1] SEL_3WAY = 21'b110110000110110000000;
  localparam int REL_OFS [1:3]   = '{29, 31, 33};
  localparam int ARITH_OFS [1:4] = '{35, 36, 37, 38};

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT} cfg_state_t;

  typedef struct packed {
    int32_t [CONS_N:1] cons;
    int2_t  [21:1]     sel;
    int2_t  [3:1]      rel_op;
    bool    [4:1]      arith_op;
  } cfg_t;

  // Words 0..11 are taken whole; only bits [6:0] of word 12 reach ctl.
  function automatic cfg_t cfg_unpack(input int32_t [11:0] w, input logic [6:0] ctl_hi);
    cfg_t             c;
    logic [CTL_W-1:0] ctl;
    ctl = {ctl_hi, w[11]};
    c   = '0;
    for (int i = 1; i <= CONS_N; i++) c.cons[i] = w[i-1];
    for (int i = 1; i <= 21; i++)
      c.sel[i] = SEL_3WAY[i] ? ctl[SEL_OFS[i] +: 2] : {1'b0, ctl[SEL_OFS[i]]};
    for (int i = 1; i <= 3; i++) c.rel_op[i] = ctl[REL_OFS[i] +: 2];
    for (int i = 1; i <= 4; i++) c.arith_op[i] = ctl[ARITH_OFS[i]];
    return c;
  endfunction

endpackage

// File: rtl/nested_ifs_cfg_fsm.sv
// Load sequencer: word counter, IDLE/LOAD/WAIT state, handshake and commit/error strobes.
// With NESTED_IFS_CFG_CHECK_EN a failed checksum in WAIT aborts the load.
module nested_ifs_cfg_fsm
  import nested_ifs_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  input  logic       commit_en,
  input  logic       chk_ok,
  output logic       cfg_ready,
  output logic       busy,
  output logic       commit,
  output logic       cfg_err,
  output logic       wr_en,
  output logic [3:0] wr_idx,
  output logic       do_commit
);

  localparam logic [3:0] LAST_IDX = 4'(CFG_WORDS - 1);

  cfg_state_t state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       commit_reg;
  logic       err_reg, err_next;
  logic       xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      commit_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      commit_reg <= do_commit;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    do_commit  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      ST_IDLE: if (xfer) begin
        cnt_next   = cnt_reg + 4'd1;
        state_next = (CFG_WORDS == 1) ? ST_WAIT : ST_LOAD;
      end
      ST_LOAD: if (xfer) begin
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == LAST_IDX) state_next = ST_WAIT;
      end
      ST_WAIT: begin
`ifdef NESTED_IFS_CFG_CHECK_EN
        // A bad checksum aborts even while the atom is not ready to take a commit
        if (!chk_ok) begin
          err_next   = 1'b1;
          cnt_next   = '0;
          state_next = ST_IDLE;
        end
`endif
        if (commit_en && chk_ok) begin
          do_commit  = 1'b1;
          cnt_next   = '0;
          state_next = ST_IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    cfg_ready = !rst && (state_reg != ST_WAIT);
    busy      = !rst && (state_reg != ST_IDLE);
    xfer      = cfg_valid && cfg_ready;
    wr_en     = xfer;
    wr_idx    = cnt_reg;
    commit    = commit_reg;
    cfg_err   = err_reg;
  end

endmodule

// File: rtl/nested_ifs_cfg_loader.sv
// Streams config words into a shadow buffer and commits the full hole set atomically.
// Define NESTED_IFS_CFG_CHECK_EN to require a trailing XOR checksum word before committing.
module nested_ifs_cfg_loader
  import nested_ifs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i__cfg_valid,
  input  logic [31:0] i__cfg_data,
  output logic        o__cfg_ready,
  input  logic        i__commit_en,
  output logic        o__commit,
  output logic        o__busy,
  output logic        o__cfg_err,
  output logic [31:0] o__cons_1, o__cons_2, o__cons_3, o__cons_4, o__cons_5, o__cons_6,
  output logic [31:0] o__cons_7, o__cons_8, o__cons_9, o__cons_10, o__cons_11,
  output logic        o__sel_1, o__sel_2, o__sel_3, o__sel_4, o__sel_5, o__sel_6, o__sel_7,
  output logic [1:0]  o__sel_8, o__sel_9,
  output logic        o__sel_10,
  output logic [1:0]  o__sel_11, o__sel_12,
  output logic        o__sel_13, o__sel_14, o__sel_15, o__sel_16,
  output logic [1:0]  o__sel_17, o__sel_18,
  output logic        o__sel_19,
  output logic [1:0]  o__sel_20, o__sel_21,
  output logic [1:0]  o__rel_op1, o__rel_op2, o__rel_op3,
  output logic        o__arith_op1, o__arith_op2, o__arith_op3, o__arith_op4
);

  logic       wr_en, do_commit, chk_ok;
  logic [3:0] wr_idx;
  int32_t     shadow_reg [CFG_WORDS];
  int32_t [11:0] lo_words;
  cfg_t       active_reg;
  logic [21:1] unused_sel_msb;

  nested_ifs_cfg_fsm u_fsm (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (i__cfg_valid),
    .commit_en (i__commit_en),
    .chk_ok    (chk_ok),
    .cfg_ready (o__cfg_ready),
    .busy      (o__busy),
    .commit    (o__commit),
    .cfg_err   (o__cfg_err),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .do_commit (do_commit)
  );

  // Shadow words need no reset: every word is rewritten before WAIT is reachable
  for (genvar gi = 0; gi < CFG_WORDS; gi++) begin : g_shadow
    always_ff @(posedge clk) begin
      if (wr_en && wr_idx == 4'(gi)) shadow_reg[gi] <= i__cfg_data;
    end
  end

  for (genvar gi = 0; gi < 12; gi++) begin : g_lo
    assign lo_words[gi] = shadow_reg[gi];
  end

`ifdef NESTED_IFS_CFG_CHECK_EN
  int32_t chk_sum;
  always_comb begin
    chk_sum = '0;
    for (int i = 0; i < 13; i++) chk_sum = chk_sum ^ shadow_reg[i];
    chk_ok = (chk_sum == shadow_reg[13]);
  end
`else
  logic [24:0] unused_w12_hi;
  assign chk_ok        = 1'b1;
  assign unused_w12_hi = shadow_reg[12][31:7];
`endif

  always_ff @(posedge clk) begin
    if (rst) active_reg <= '0;
    else if (do_commit) active_reg <= cfg_unpack(lo_words, shadow_reg[12][6:0]);
  end

  // 2-way selectors only drive bit 0; their upper bit is always zero
  for (genvar gi = 1; gi <= 21; gi++) begin : g_sel_msb
    assign unused_sel_msb[gi] = active_reg.sel[gi][1];
  end

  assign o__cons_1  = active_reg.cons[1];
  assign o__cons_2  = active_reg.cons[2];
  assign o__cons_3  = active_reg.cons[3];
  assign o__cons_4  = active_reg.cons[4];
  assign o__cons_5  = active_reg.cons[5];
  assign o__cons_6  = active_reg.cons[6];
  assign o__cons_7  = active_reg.cons[7];
  assign o__cons_8  = active_reg.cons[8];
  assign o__cons_9  = active_reg.cons[9];
  assign o__cons_10 = active_reg.cons[10];
  assign o__cons_11 = active_reg.cons[11];

  assign o__sel_1  = active_reg.sel[1][0];
  assign o__sel_2  = active_reg.sel[2][0];
  assign o__sel_3  = active_reg.sel[3][0];
  assign o__sel_4  = active_reg.sel[4][0];
  assign o__sel_5  = active_reg.sel[5][0];
  assign o__sel_6  = active_reg.sel[6][0];
  assign o__sel_7  = active_reg.sel[7][0];
  assign o__sel_8  = active_reg.sel[8];
  assign o__sel_9  = active_reg.sel[9];
  assign o__sel_10 = active_reg.sel[10][0];
  assign o__sel_11 = active_reg.sel[11];
  assign o__sel_12 = active_reg.sel[12];
  assign o__sel_13 = active_reg.sel[13][0];
  assign o__sel_14 = active_reg.sel[14][0];
  assign o__sel_15 = active_reg.sel[15][0];
  assign o__sel_16 = active_reg.sel[16][0];
  assign o__sel_17 = active_reg.sel[17];
  assign o__sel_18 = active_reg.sel[18];
  assign o__sel_19 = active_reg.sel[19][0];
  assign o__sel_20 = active_reg.sel[20];
  assign o__sel_21 = active_reg.sel[21];

  assign o__rel_op1   = active_reg.rel_op[1];
  assign o__rel_op2   = active_reg.rel_op[2];
  assign o__rel_op3   = active_reg.rel_op[3];
  assign o__arith_op1 = active_reg.arith_op[1];
  assign o__arith_op2 = active_reg.arith_op[2];
  assign o__arith_op3 = active_reg.arith_op[3];
  assign o__arith_op4 = active_reg.arith_op[4];

endmodule
